// File: rtl/sub_bytes_seq_if.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq_if
// Valid/ready bus for the sequential AES SubBytes stage.
//   in_valid / in_ready / in_data[127:0]    : upstream state transfer
//   out_valid / out_ready / out_data[127:0] : result transfer toward ShiftRows
// Byte k of either data bus sits in bits [8k+7:8k].
// Modports: slave  = the SubBytes block itself
//           master = the environment (upstream source and downstream sink)
// -----------------------------------------------------------------------------
interface sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq
// AES SubBytes over a 128-bit state using one shared, registered S-box that is
// fed one byte per cycle. Accept -> out_valid takes 17 rising edges; with
// out_ready held high a new state can be accepted every 19 cycles.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : sub_bytes_seq_if.slave (input and output valid/ready channels)
//   busy : high whenever the FSM is not in IDLE
//   err  : sticky S-box echo mismatch flag
// Optional feature: define SUB_BYTES_ECHO_CHECK_EN to compare the S-box echoed
// input (my_x) against the byte issued one cycle earlier; without it err is 0.
// -----------------------------------------------------------------------------

// Registered AES S-box: y = S(x), my_x = x, both one cycle after x.
// S(x) is computed as the GF(2^8) inverse (x^254) followed by the affine map.
module sbox (
  input  logic       clk,
  input  logic [7:0] x,
  output logic [7:0] y,
  output logic [7:0] my_x
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] r;
    // r accumulates a^2 * a^4 * ... * a^128 = a^254 (inverse; 0 maps to 0)
    t = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  always_ff @(posedge clk) begin
    y    <= sbox_f(x);
    my_x <= x;
  end
endmodule

module sub_bytes_seq (
  input  logic              clk,
  input  logic              rst,
  sub_bytes_seq_if.slave    bus,
  output logic              busy,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q;
  logic [3:0]   cap_idx_q;   // byte index whose S-box result is on sbox_y
  logic         cap_vld_q;   // sbox_y carries a result to capture this cycle
  logic [7:0]   data_q   [16];
  logic [7:0]   result_q [16];
  logic [7:0]   sbox_x;
  logic [7:0]   sbox_y;
  logic [127:0] out_data_w;
  logic         accept;

  assign accept = (state_q == IDLE) && bus.in_valid;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.in_valid)     state_d = ISSUE;
      ISSUE: if (cnt_q == 4'd15)   state_d = DRAIN;
      DRAIN:                       state_d = HOLD;
      HOLD:  if (bus.out_ready)    state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    sbox_x        = 8'h00;
    case (state_q)
      IDLE:  begin bus.in_ready = 1'b1; busy = 1'b0; end
      ISSUE: sbox_x = data_q[cnt_q];
      HOLD:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------- input latch, issue counter, capture tracking ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      cap_idx_q <= 4'd0;
      cap_vld_q <= 1'b0;
      for (int i = 0; i < 16; i++) data_q[i] <= 8'h00;
    end else begin
      if (accept) begin
        cnt_q <= 4'd0;
        for (int i = 0; i < 16; i++) data_q[i] <= bus.in_data[i*8 +: 8];
      end else if (state_q == ISSUE) begin
        cnt_q <= cnt_q + 4'd1;
      end
      cap_vld_q <= (state_q == ISSUE);
      cap_idx_q <= cnt_q;
    end
  end

  // ---------------- per-byte result registers ----------------
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_res
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     result_q[gi] <= 8'h00;
        else if (cap_vld_q && cap_idx_q == 4'(gi))   result_q[gi] <= sbox_y;
      end
    end
  endgenerate

  always_comb begin
    out_data_w = '0;
    for (int i = 0; i < 16; i++) out_data_w[i*8 +: 8] = result_q[i];
  end
  assign bus.out_data = out_data_w;

`ifdef SUB_BYTES_ECHO_CHECK_EN
  logic [7:0] sbox_my_x;
  logic       err_q;

  sbox u_sbox (.clk(clk), .x(sbox_x), .y(sbox_y), .my_x(sbox_my_x));

  // The echoed input must equal the byte issued on the previous cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                 err_q <= 1'b0;
    else if (cap_vld_q && (sbox_my_x != data_q[cap_idx_q]))  err_q <= 1'b1;
  end
  assign err = err_q;
`else
  sbox u_sbox (.clk(clk), .x(sbox_x), .y(sbox_y), .my_x());
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_seq
// Directed vectors for sub_bytes_seq with hand-computed S-box results.
// -----------------------------------------------------------------------------
module tb_sub_bytes_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;
  int   n_vec = 0;
  int   n_err = 0;

  sub_bytes_seq_if bus();

  sub_bytes_seq dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err));

  always #5 clk = ~clk;

  localparam logic [127:0] V_ZERO = 128'h0;
  localparam logic [127:0] E_ZERO = {16{8'h63}};
  localparam logic [127:0] V_SEQ  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] E_SEQ  = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] V_53   = {16{8'h53}};
  localparam logic [127:0] E_53   = {16{8'hed}};
  localparam logic [127:0] V_MIX  = {4{32'h0010ff53}};
  localparam logic [127:0] E_MIX  = {4{32'h63ca16ed}};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Send one block, check latency/result, optionally stall out_ready for hold cycles.
  task automatic send(input string tag, input logic [127:0] d, input logic [127:0] e,
                      input int hold);
    int lat;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    check({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;  // must be ignored while busy
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(17));
    check({tag, "_data"}, bus.out_data, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 128'(bus.out_valid), 128'(1));
      check({tag, "_hold_data"}, bus.out_data, e);
      check({tag, "_hold_in_ready"}, 128'(bus.in_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_released"}, 128'(bus.out_valid), 128'(0));
    check({tag, "_idle_busy"}, 128'(busy), 128'(0));
    $display("vector %s: data %h -> %h latency %0d", tag, d, bus.out_data, lat);
  endtask

  initial begin
    int n, seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_data", bus.out_data, 128'h0);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    $display("reset: in_ready=%0d out_valid=%0d busy=%0d", bus.in_ready, bus.out_valid, busy);

    send("zero", V_ZERO, E_ZERO, 0);
    send("seq",  V_SEQ,  E_SEQ,  0);
    send("x53",  V_53,   E_53,   0);
    send("stall", V_MIX, E_MIX, 10);

    // Back-to-back: in_valid and out_ready stay high throughout.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = V_SEQ;
    @(posedge clk); #1;
    bus.in_data = V_53;
    n = 0;
    seen = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) begin
        check("b2b_first_data", bus.out_data, E_SEQ);
        seen = 1;
      end
      if (bus.in_ready) break;
    end
    check("b2b_first_seen", 128'(seen), 128'(1));
    check("b2b_interval", 128'(n), 128'(19));
    $display("back-to-back: second accept %0d cycles after first", n);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_second_latency", 128'(n), 128'(17));
    check("b2b_second_data", bus.out_data, E_53);
    @(posedge clk); #1;
    $display("back-to-back: second block -> %h", E_53);

    // Reset at cnt=7 discards the block.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = V_SEQ;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    check("midrst_out_data", bus.out_data, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("midrst_no_valid", 128'(seen), 128'(0));
    $display("mid-block reset: out_valid seen=%0d", seen);
    send("after_rst", V_MIX, E_MIX, 0);

`ifdef SUB_BYTES_ECHO_CHECK_EN
    check("echo_clean_err", 128'(err), 128'(0));
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = V_ZERO;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    force dut.u_sbox.my_x = 8'haa;
    @(posedge clk); #1;
    release dut.u_sbox.my_x;
    repeat (25) @(posedge clk);
    #1;
    check("echo_err_set", 128'(err), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("echo_err_cleared", 128'(err), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    $display("echo check: err flagged and cleared by reset");
`else
    check("err_tied_low", 128'(err), 128'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sub_bytes_seq.md
SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream offers a 128-bit AES state.
REQ-005 in_ready  output  1  block accepts a state; transfer occurs on a rising edge with in_valid&in_ready.
REQ-006 in_data  input  128  state; byte k = in_data[8k+7:8k], k=0..15.
REQ-007 out_valid  output  1  out_data holds a completed SubBytes result.
REQ-008 out_ready  input  1  downstream (ShiftRows) accepts; transfer occurs on a rising edge with out_valid&out_ready.
REQ-009 out_data  output  128  result; byte k = S(in byte k), same bit mapping as in_data.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 err  output  1  sticky echo-mismatch flag (see Configuration).

Function
REQ-012 One instance of the team's sbox (ports clk, x, y, my_x; y=S(x) and my_x=x, both registered, 1-cycle latency) performs all substitutions.
REQ-013 FSM states: IDLE, ISSUE, DRAIN, HOLD.
REQ-014 IDLE: in_ready=1; on input handshake, latch in_data into an internal register, clear the 4-bit issue counter, go to ISSUE.
REQ-015 ISSUE: drive sbox x = latched byte[cnt], with cnt running 0..15 on successive cycles; after cnt=15 is issued, go to DRAIN.
REQ-016 Each y is written into result byte[cnt_d], where cnt_d is cnt delayed one cycle; byte 15 is captured in DRAIN.
REQ-017 DRAIN lasts exactly one cycle, then go to HOLD.
REQ-018 HOLD: out_valid=1 and out_data stable; on output handshake, go to IDLE.
REQ-019 Latency: out_valid rises on the 17th rising edge after the accepting edge.
REQ-020 Minimum initiation interval is 19 cycles, with out_ready held high.
REQ-021 in_ready=0 outside IDLE; in_valid is ignored there and in_data changes have no effect.
REQ-022 out_valid may not deassert without a handshake; out_ready low holds HOLD indefinitely.
REQ-023 When the sbox is idle, x=0x00.

Reset
REQ-024 rst asserted at any time: state=IDLE, cnt=0, in_ready=1 after release, out_valid=0, out_data=0, busy=0, err=0, internal registers cleared.
REQ-025 Reset mid-operation discards the partial result; no out_valid follows for that block.
REQ-026 Reset takes effect asynchronously; deassertion is assumed synchronous to clk by the integrating level.

Configuration
REQ-027 Macro SUB_BYTES_ECHO_CHECK_EN defined: on each capture, compare sbox my_x with the byte issued one cycle earlier; a mismatch sets err=1, which stays set until rst.
REQ-028 SUB_BYTES_ECHO_CHECK_EN undefined: no compare logic; err is tied to 0; my_x is left unconnected.
REQ-029 Function, latency and throughput are identical with and without the macro.

Verification
REQ-030 in_data all 0x00 -> out_data all 0x63, out_valid on the 17th edge after accept.
REQ-031 in bytes k=0..15 = 0x00..0x0F -> out bytes 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76; byte with value 0x53 -> 0xED.
REQ-032 out_ready held low 10 cycles in HOLD -> out_valid and out_data stable; in_ready=0 throughout; completes on release.
REQ-033 Two blocks back-to-back with in_valid and out_ready always high -> accepts 19 cycles apart, both results correct.
REQ-034 rst pulsed at cnt=7 -> IDLE, out_valid never rises for that block; next block then processes correctly.
REQ-035 Macro defined with my_x forced wrong for one cycle -> err=1 and sticky until rst; normal runs keep err=0.
